address_issue_ctrl: RTL and testbench

ADDRESS_ISSUE_CTRL -- requirements
Module: address_issue_ctrl

---
 rtl/addr_ctrl_pkg.sv | 25 ++
 rtl/address_wb_tracker.sv | 50 +++++
 rtl/address_issue_ctrl.sv | 110 +++++++++++
 tb/tb_address_issue_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_ctrl_pkg.sv
// Shared definitions for the address-unit issue controller.
//   - opcode constants for the address sum/diff functional unit
//   - A-register count / index width and the default unit latency
//   - tracker entry type used by the writeback shift line
package addr_ctrl_pkg;

    localparam int OPC_W       = 7;
    localparam int AREG_W      = 3;
    localparam int NREG_DEF    = 8;
    localparam int LATENCY_DEF = 6;

    localparam logic [OPC_W-1:0] OP_NOP   = 7'o000;
    localparam logic [OPC_W-1:0] OP_ASUM  = 7'o020;
    localparam logic [OPC_W-1:0] OP_ADIFF = 7'o021;

    typedef struct packed {
        logic              valid;
        logic [AREG_W-1:0] dest;
    } trk_entry_t;

    function automatic logic is_addr_op(input logic [OPC_W-1:0] op);
        return (op == OP_ASUM) || (op == OP_ADIFF);
    endfunction

endpackage

// File: rtl/address_wb_tracker.sv
// Writeback tracker: a LATENCY-deep shift line of {valid, dest} entries.
// An entry is loaded on the edge that ends the unit's o_Instr cycle, so the
// last stage lines up with the unit's result on o_Ai.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_flush             clear every stage (input entry is dropped too)
//   i_valid, i_dest     entry entering the line (unit opcode cycle)
//   o_wb_valid/o_wb_addr last stage: write result to A[o_wb_addr] this cycle
//   o_wb_next           an entry will reach the last stage on the next edge
module address_wb_tracker
    import addr_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [AREG_W-1:0] i_dest,
    output logic              o_wb_valid,
    output logic [AREG_W-1:0] o_wb_addr,
    output logic              o_wb_next
);

    trk_entry_t line_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < LATENCY; i++) line_q[i] <= '0;
        end else begin
            line_q[0].valid <= i_valid;
            line_q[0].dest  <= i_dest;
            for (int i = 1; i < LATENCY; i++) line_q[i] <= line_q[i-1];
        end
    end

    assign o_wb_valid = line_q[LATENCY-1].valid;
    assign o_wb_addr  = line_q[LATENCY-1].dest;

    generate
        if (LATENCY > 1) begin : g_next_stage
            assign o_wb_next = line_q[LATENCY-2].valid;
        end else begin : g_next_input
            assign o_wb_next = i_valid;
        end
    endgenerate

endmodule

// File: rtl/address_issue_ctrl.sv
// Issue controller for the address sum/diff unit (A registers).
// Accepts one decoded add/subtract per clock, stalls on RAW/WAW hazards
// against a per-register reservation bitmap, and schedules the writeback
// LATENCY cycles after the unit's opcode cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   i_valid, i_Instr           decoded instruction and opcode (020 add, 021 sub)
//   i_i, i_j, i_k              destination / source A-register indices
//   i_flush                    discard all in-flight tracking
//   o_ready                    combinational accept for the presented instruction
//   o_Instr, o_Aj_sel, o_Ak_sel unit opcode (000 when idle) and read selects
//   o_wb_valid, o_wb_addr      write unit result into A[o_wb_addr]
//   o_illegal                  pulse: presented opcode dropped
//   o_resv                     reservation bitmap, bit n = An pending
//   o_inflight                 issued instructions whose writeback is not yet due
module address_issue_ctrl
    import addr_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int NREG    = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [6:0]        i_Instr,
    input  logic [2:0]        i_i,
    input  logic [2:0]        i_j,
    input  logic [2:0]        i_k,
    input  logic              i_flush,
    output logic              o_ready,
    output logic [6:0]        o_Instr,
    output logic [2:0]        o_Aj_sel,
    output logic [2:0]        o_Ak_sel,
    output logic              o_wb_valid,
    output logic [2:0]        o_wb_addr,
    output logic              o_illegal,
    output logic [NREG-1:0]   o_resv,
    output logic [2:0]        o_inflight
);

    logic              legal;
    logic              hazard;
    logic              accept;
    logic              issue;
    logic              wb_next;
    logic [NREG-1:0]   resv_q;
    logic [NREG-1:0]   resv_d;
    logic [AREG_W-1:0] dest_q;

    assign legal   = is_addr_op(i_Instr);
    assign hazard  = resv_q[i_i] | resv_q[i_j] | resv_q[i_k];
    assign o_ready = !i_flush && !hazard;
    assign accept  = i_valid && o_ready;
    assign issue   = accept && legal;
    assign o_resv  = resv_q;

    // The destination of an issuing instruction is stalled while reserved, so
    // a writeback clear and a new set never target the same bit in practice;
    // the set is applied last so it would win anyway.
    always_comb begin
        resv_d = resv_q;
        if (o_wb_valid) resv_d[o_wb_addr] = 1'b0;
        if (issue)      resv_d[i_i]       = 1'b1;
        if (i_flush)    resv_d            = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_Instr    <= OP_NOP;
            o_Aj_sel   <= '0;
            o_Ak_sel   <= '0;
            dest_q     <= '0;
            o_illegal  <= 1'b0;
            resv_q     <= '0;
            o_inflight <= '0;
        end else begin
            o_Instr   <= issue ? i_Instr : OP_NOP;
            o_illegal <= accept && !legal;
            resv_q    <= resv_d;
            if (issue) begin
                o_Aj_sel <= i_j;
                o_Ak_sel <= i_k;
                dest_q   <= i_i;
            end
            // Count drops on the edge that raises o_wb_valid, which keeps the
            // count within LATENCY under continuous one-per-clock issue.
            if (i_flush) begin
                o_inflight <= '0;
            end else if (issue && !wb_next) begin
                o_inflight <= o_inflight + 3'd1;
            end else if (!issue && wb_next) begin
                o_inflight <= o_inflight - 3'd1;
            end
        end
    end

    address_wb_tracker #(
        .LATENCY (LATENCY)
    ) u_wb_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (i_flush),
        .i_valid    (o_Instr != OP_NOP),
        .i_dest     (dest_q),
        .o_wb_valid (o_wb_valid),
        .o_wb_addr  (o_wb_addr),
        .o_wb_next  (wb_next)
    );

endmodule

// File: tb/tb_address_issue_ctrl.sv
// Directed bench for address_issue_ctrl (LATENCY=6, NREG=8).
module tb_address_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_valid;
    logic [6:0] i_Instr;
    logic [2:0] i_i, i_j, i_k;
    logic       i_flush;
    logic       o_ready;
    logic [6:0] o_Instr;
    logic [2:0] o_Aj_sel, o_Ak_sel;
    logic       o_wb_valid;
    logic [2:0] o_wb_addr;
    logic       o_illegal;
    logic [7:0] o_resv;
    logic [2:0] o_inflight;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    address_issue_ctrl #(.LATENCY(6), .NREG(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_Instr    (i_Instr),
        .i_i        (i_i),
        .i_j        (i_j),
        .i_k        (i_k),
        .i_flush    (i_flush),
        .o_ready    (o_ready),
        .o_Instr    (o_Instr),
        .o_Aj_sel   (o_Aj_sel),
        .o_Ak_sel   (o_Ak_sel),
        .o_wb_valid (o_wb_valid),
        .o_wb_addr  (o_wb_addr),
        .o_illegal  (o_illegal),
        .o_resv     (o_resv),
        .o_inflight (o_inflight)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [2:0] ii, input logic [2:0] jj, input logic [2:0] kk);
        i_valid = v;
        i_Instr = op;
        i_i     = ii;
        i_j     = jj;
        i_k     = kk;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_flush = 1'b0;
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        #22;
        check("rst_instr",    o_Instr,    7'o000);
        check("rst_resv",     o_resv,     8'h00);
        check("rst_inflight", o_inflight, 3'd0);
        check("rst_wb",       o_wb_valid, 1'b0);
        check("rst_illegal",  o_illegal,  1'b0);
        rst_n = 1'b1;

        // Basic add, first edge after reset release.
        drive(1'b1, 7'o020, 3'd3, 3'd1, 3'd2);
        #1 check("t1_ready", o_ready, 1'b1);
        tick();
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t1_instr",    o_Instr,    7'o020);
        check("t1_aj",       o_Aj_sel,   3'd1);
        check("t1_ak",       o_Ak_sel,   3'd2);
        check("t1_resv",     o_resv,     8'h08);
        check("t1_inflight", o_inflight, 3'd1);
        tick();
        check("t1_instr_nop", o_Instr,  7'o000);
        check("t1_aj_hold",   o_Aj_sel, 3'd1);
        for (int n = 2; n <= 6; n++) begin
            check("t1_no_wb_early", o_wb_valid, 1'b0);
            tick();
        end
        check("t1_wb",        o_wb_valid, 1'b1);
        check("t1_wb_addr",   o_wb_addr,  3'd3);
        check("t1_resv_wb",   o_resv,     8'h08);
        check("t1_infl_wb",   o_inflight, 3'd0);
        tick();
        check("t1_wb_end",    o_wb_valid, 1'b0);
        check("t1_resv_end",  o_resv,     8'h00);

        // RAW stall: sub A4, then add reading A4.
        drive(1'b1, 7'o021, 3'd4, 3'd0, 3'd0);
        tick();
        drive(1'b1, 7'o020, 3'd5, 3'd4, 3'd1);
        for (int n = 1; n <= 7; n++) begin
            #1 check("t2_stall", o_ready, 1'b0);
            if (n == 7) begin
                check("t2_wb",      o_wb_valid, 1'b1);
                check("t2_wb_addr", o_wb_addr,  3'd4);
            end
            tick();
        end
        #1 check("t2_ready", o_ready, 1'b1);
        tick();
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t2_instr", o_Instr,  7'o020);
        check("t2_aj",    o_Aj_sel, 3'd4);
        check("t2_ak",    o_Ak_sel, 3'd1);
        check("t2_resv",  o_resv,   8'h20);
        repeat (8) tick();
        check("t2_resv_end", o_resv,     8'h00);
        check("t2_infl_end", o_inflight, 3'd0);

        // Six independent issues back to back.
        for (int n = 0; n < 6; n++) begin
            drive(1'b1, 7'o020, 3'(n), 3'd6, 3'd7);
            tick();
            check("t3_inflight", o_inflight, 32'(n + 1));
        end
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t3_resv_peak", o_resv, 8'h3F);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("t3_wb",      o_wb_valid, 1'b1);
            check("t3_wb_addr", o_wb_addr,  32'(n));
        end
        tick();
        check("t3_wb_end",   o_wb_valid, 1'b0);
        check("t3_resv_end", o_resv,     8'h00);
        check("t3_infl_end", o_inflight, 3'd0);

        // Illegal opcode.
        drive(1'b1, 7'o022, 3'd2, 3'd0, 3'd0);
        #1 check("t4_ready", o_ready, 1'b1);
        tick();
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t4_illegal", o_illegal,  1'b1);
        check("t4_instr",   o_Instr,    7'o000);
        check("t4_resv",    o_resv,     8'h00);
        check("t4_infl",    o_inflight, 3'd0);
        tick();
        check("t4_illegal_end", o_illegal, 1'b0);
        for (int n = 0; n < 8; n++) begin
            check("t4_no_wb", o_wb_valid, 1'b0);
            tick();
        end

        // Flush with three in flight.
        for (int n = 1; n <= 3; n++) begin
            drive(1'b1, 7'o020, 3'(n), 3'd0, 3'd0);
            tick();
        end
        check("t5_infl_pre", o_inflight, 3'd3);
        check("t5_resv_pre", o_resv,     8'h0E);
        drive(1'b1, 7'o020, 3'd6, 3'd0, 3'd0);
        i_flush = 1'b1;
        #1 check("t5_flush_ready", o_ready, 1'b0);
        tick();
        i_flush = 1'b0;
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t5_resv",  o_resv,     8'h00);
        check("t5_infl",  o_inflight, 3'd0);
        check("t5_instr", o_Instr,    7'o000);
        for (int n = 0; n < 10; n++) begin
            check("t5_no_wb", o_wb_valid, 1'b0);
            tick();
        end

        // Flush in the writeback cycle: that writeback still goes out.
        drive(1'b1, 7'o021, 3'd1, 3'd2, 3'd3);
        tick();
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        repeat (6) tick();
        i_flush = 1'b1;
        #1;
        check("t5b_wb",      o_wb_valid, 1'b1);
        check("t5b_wb_addr", o_wb_addr,  3'd1);
        tick();
        i_flush = 1'b0;
        check("t5b_wb_end",  o_wb_valid, 1'b0);
        check("t5b_resv",    o_resv,     8'h00);
        check("t5b_infl",    o_inflight, 3'd0);

        // Reset with two in flight.
        drive(1'b1, 7'o020, 3'd6, 3'd3, 3'd4);
        tick();
        drive(1'b1, 7'o021, 3'd7, 3'd5, 3'd5);
        tick();
        drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
        check("t6_infl_pre", o_inflight, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_resv",  o_resv,     8'h00);
        check("t6_infl",  o_inflight, 3'd0);
        check("t6_instr", o_Instr,    7'o000);
        check("t6_aj",    o_Aj_sel,   3'd0);
        check("t6_ak",    o_Ak_sel,   3'd0);
        check("t6_wb",    o_wb_valid, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("t6_no_wb", o_wb_valid, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
